// File: rtl/sdram_capture_writer.sv
// Capture-side SDRAM write master: packs ADC byte pairs into 16-bit words, buffers them in a
// small FIFO and streams them to sequential SDRAM word addresses over Avalon-MM.
module sdram_capture_writer #(
  parameter int unsigned       ADDR_W    = 25,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       FIFO_AW   = 4
) (
  input  logic              M100CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] length,
  input  logic [7:0]        adc_data,
  input  logic              adc_valid,
  output logic              avm_chipselect,
  output logic [ADDR_W-1:0] avm_address,
  output logic [1:0]        avm_byteenable,
  output logic [15:0]       avm_writedata,
  output logic              avm_write,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] words_written
);

  localparam int unsigned Depth = 2 ** FIFO_AW;

  typedef enum logic [1:0] {StIdle, StCapture, StDrain, StDone} state_e;

  state_e              state_q;
  logic                busy_q, done_q;
  logic [ADDR_W-1:0]   len_q, pushed_q, wcount_q;
  logic                phase_q;
  logic [7:0]          low_q;
  logic                overflow_q;

  logic [15:0]         mem_q [Depth];
  logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]    count_q;

  logic fifo_empty, fifo_full, pop, push_req, push_ok, last_push;

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == (FIFO_AW + 1)'(Depth));
    pop        = !fifo_empty && !avm_waitrequest;
    push_req   = (state_q == StCapture) && adc_valid && phase_q;
    // A completing pop frees a slot on the same edge, so a push into a full FIFO still lands.
    push_ok    = push_req && (!fifo_full || pop);
    last_push  = push_req && ((pushed_q + ADDR_W'(1)) == len_q);
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge M100CLK) begin
    if (reset) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      len_q      <= '0;
      pushed_q   <= '0;
      phase_q    <= 1'b0;
      low_q      <= '0;
      overflow_q <= 1'b0;
      wcount_q   <= '0;
    end else begin
      if (pop) wcount_q <= wcount_q + ADDR_W'(1);
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            len_q      <= length;
            pushed_q   <= '0;
            phase_q    <= 1'b0;
            overflow_q <= 1'b0;
            wcount_q   <= '0;
            if (length == '0) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= StCapture;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        StCapture: begin
          if (adc_valid) begin
            if (!phase_q) begin
              low_q   <= adc_data;
              phase_q <= 1'b1;
            end else begin
              phase_q  <= 1'b0;
              // Dropped words still count toward the requested length.
              pushed_q <= pushed_q + ADDR_W'(1);
              if (!push_ok) overflow_q <= 1'b1;
              if (last_push) state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (fifo_empty) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge M100CLK) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + (FIFO_AW + 1)'(1);
        2'b01:   count_q <= count_q - (FIFO_AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge M100CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= {adc_data, low_q};
  end

  always_comb begin
    avm_write      = !fifo_empty;
    avm_chipselect = avm_write;
    avm_byteenable = avm_write ? 2'b11 : 2'b00;
    // Address and data are forced to zero when idle so every output is zero out of reset.
    avm_address    = avm_write ? (BASE_ADDR + wcount_q) : '0;
    avm_writedata  = avm_write ? mem_q[rd_ptr_q] : '0;
    busy           = busy_q;
    done           = done_q;
    overflow       = overflow_q;
    words_written  = wcount_q;
  end

endmodule

// File: tb/tb_sdram_capture_writer.sv
// Directed bench for sdram_capture_writer; three instances share stimulus and differ in BASE_ADDR.
module tb_sdram_capture_writer;

  logic        clk = 1'b0;
  logic        reset, start, adc_valid, waitreq;
  logic [24:0] length;
  logic [7:0]  adc_data;

  logic        cs [3];
  logic [24:0] addr [3];
  logic [1:0]  be [3];
  logic [15:0] wdata [3];
  logic        wr [3];
  logic        busy [3];
  logic        done [3];
  logic        ovf [3];
  logic [24:0] wcnt [3];

  logic [40:0] q0[$], q1[$], q2[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sdram_capture_writer #(.ADDR_W(25), .BASE_ADDR(25'h0000000), .FIFO_AW(4)) u0 (
    .M100CLK(clk), .reset(reset), .start(start), .length(length), .adc_data(adc_data),
    .adc_valid(adc_valid), .avm_chipselect(cs[0]), .avm_address(addr[0]),
    .avm_byteenable(be[0]), .avm_writedata(wdata[0]), .avm_write(wr[0]),
    .avm_waitrequest(waitreq), .busy(busy[0]), .done(done[0]), .overflow(ovf[0]),
    .words_written(wcnt[0]));

  sdram_capture_writer #(.ADDR_W(25), .BASE_ADDR(25'h1FFFFFF), .FIFO_AW(4)) u1 (
    .M100CLK(clk), .reset(reset), .start(start), .length(length), .adc_data(adc_data),
    .adc_valid(adc_valid), .avm_chipselect(cs[1]), .avm_address(addr[1]),
    .avm_byteenable(be[1]), .avm_writedata(wdata[1]), .avm_write(wr[1]),
    .avm_waitrequest(waitreq), .busy(busy[1]), .done(done[1]), .overflow(ovf[1]),
    .words_written(wcnt[1]));

  sdram_capture_writer #(.ADDR_W(25), .BASE_ADDR(25'h1FFFFFE), .FIFO_AW(4)) u2 (
    .M100CLK(clk), .reset(reset), .start(start), .length(length), .adc_data(adc_data),
    .adc_valid(adc_valid), .avm_chipselect(cs[2]), .avm_address(addr[2]),
    .avm_byteenable(be[2]), .avm_writedata(wdata[2]), .avm_write(wr[2]),
    .avm_waitrequest(waitreq), .busy(busy[2]), .done(done[2]), .overflow(ovf[2]),
    .words_written(wcnt[2]));

  // Completed transfers, sampled mid-cycle before the completing edge.
  always @(negedge clk) begin
    if (wr[0] && !waitreq) q0.push_back({addr[0], wdata[0]});
    if (wr[1] && !waitreq) q1.push_back({addr[1], wdata[1]});
    if (wr[2] && !waitreq) q2.push_back({addr[2], wdata[2]});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [24:0] len);
    length = len;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic sample(input logic [7:0] d);
    adc_data  = d;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done[0] && n < 200) begin
      tick();
      n++;
    end
    chk(tag, done[0], 1);
  endtask

  function automatic logic [40:0] qget(input int which, input int i);
    logic [40:0] v;
    v = '1;
    if (which == 0 && i < q0.size()) v = q0[i];
    if (which == 1 && i < q1.size()) v = q1[i];
    if (which == 2 && i < q2.size()) v = q2[i];
    return v;
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; adc_valid = 1'b0; waitreq = 1'b0;
    length = '0; adc_data = '0;
    tick(); tick();

    // Reset state
    chk("rst_write", wr[0], 0);
    chk("rst_cs", cs[0], 0);
    chk("rst_be", be[0], 0);
    chk("rst_addr_base_ffffff", addr[1], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_ovf", ovf[0], 0);
    chk("rst_wcnt", wcnt[0], 0);
    reset = 1'b0;
    tick();

    // Basic path
    q0.delete(); q1.delete(); q2.delete();
    do_start(25'd4);
    chk("basic_busy", busy[0], 1);
    for (int i = 1; i <= 8; i++) begin
      adc_data  = 8'(i);
      adc_valid = 1'b1;
      tick();
      if (i == 1) chk("basic_no_early_write", wr[0], 0);
      if (i == 2) begin
        chk("basic_latency_write", wr[0], 1);
        chk("basic_latency_data", wdata[0], 16'h0201);
        chk("basic_be", be[0], 2'b11);
      end
    end
    adc_valid = 1'b0;
    wait_done("basic_done");
    chk("basic_nwrites", q0.size(), 4);
    for (int j = 0; j < 4; j++) begin
      logic [7:0] lo, hi;
      lo = 8'(2 * j + 1);
      hi = 8'(2 * j + 2);
      chk($sformatf("basic_wr%0d", j), qget(0, j), {25'(j), hi, lo});
    end
    chk("basic_wcnt", wcnt[0], 4);
    chk("basic_ovf", ovf[0], 0);
    chk("basic_busy_end", busy[0], 0);

    // Stall hold
    q0.delete(); q1.delete(); q2.delete();
    waitreq = 1'b1;
    do_start(25'd2);
    sample(8'hAA);
    sample(8'hBB);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall_wr_c%0d", c), {wr[0], addr[0], wdata[0]}, {1'b1, 25'd0, 16'hBBAA});
      if (c == 0) begin adc_data = 8'hCC; adc_valid = 1'b1; end
      if (c == 1) begin adc_data = 8'hDD; adc_valid = 1'b1; end
      tick();
      adc_valid = 1'b0;
    end
    waitreq = 1'b0;
    wait_done("stall_done");
    chk("stall_nwrites", q0.size(), 2);
    chk("stall_wr0", qget(0, 0), {25'd0, 16'hBBAA});
    chk("stall_wr1", qget(0, 1), {25'd1, 16'hDDCC});

    // Overflow: waitrequest held until all 40 words have been offered
    q0.delete(); q1.delete(); q2.delete();
    waitreq = 1'b1;
    do_start(25'd40);
    for (int k = 0; k < 80; k++) begin
      adc_data  = 8'(k);
      adc_valid = 1'b1;
      tick();
      if (k == 31) chk("ovf_full_no_flag", ovf[0], 0);
      if (k == 33) chk("ovf_flag_set", ovf[0], 1);
    end
    adc_valid = 1'b0;
    chk("ovf_draining_busy", busy[0], 1);
    chk("ovf_draining_wcnt", wcnt[0], 0);
    waitreq = 1'b0;
    wait_done("ovf_done");
    chk("ovf_nwrites", q0.size(), 16);
    for (int j = 0; j < 16; j++) begin
      logic [7:0] lo, hi;
      lo = 8'(2 * j);
      hi = 8'(2 * j + 1);
      chk($sformatf("ovf_wr%0d", j), qget(0, j), {25'(j), hi, lo});
    end
    chk("ovf_wcnt", wcnt[0], 16);
    chk("ovf_sticky", ovf[0], 1);

    // Zero length, then restart with length 1 on the top-of-memory base
    q0.delete(); q1.delete(); q2.delete();
    do_start(25'd0);
    chk("zero_done", done[0], 1);
    chk("zero_busy", busy[0], 0);
    chk("zero_write", wr[0], 0);
    chk("zero_ovf_cleared", ovf[0], 0);
    chk("zero_wcnt_cleared", wcnt[0], 0);
    do_start(25'd1);
    chk("restart_busy", busy[1], 1);
    chk("restart_not_done", done[1], 0);
    sample(8'h11);
    sample(8'h22);
    wait_done("restart_done");
    chk("restart_nwrites", q1.size(), 1);
    chk("restart_wr0", qget(1, 0), {25'h1FFFFFF, 16'h2211});
    chk("restart_ovf", ovf[1], 0);
    chk("restart_wcnt", wcnt[1], 1);

    // Address wrap on the 0x1FFFFFE base
    q0.delete(); q1.delete(); q2.delete();
    do_start(25'd4);
    for (int i = 1; i <= 8; i++) sample(8'(i));
    wait_done("wrap_done");
    chk("wrap_nwrites", q2.size(), 4);
    chk("wrap_a0", qget(2, 0) >> 16, 25'h1FFFFFE);
    chk("wrap_a1", qget(2, 1) >> 16, 25'h1FFFFFF);
    chk("wrap_a2", qget(2, 2) >> 16, 25'h0000000);
    chk("wrap_a3", qget(2, 3) >> 16, 25'h0000001);
    chk("wrap_wcnt_held", wcnt[2], 4);

    // Reset in the middle of a stalled write
    waitreq = 1'b1;
    do_start(25'd4);
    sample(8'h55);
    sample(8'h66);
    chk("rstmid_pre_write", wr[0], 1);
    reset = 1'b1; start = 1'b1; adc_valid = 1'b1; length = 25'd3;
    tick();
    chk("rstmid_write", wr[0], 0);
    chk("rstmid_busy", busy[0], 0);
    chk("rstmid_done", done[0], 0);
    tick();
    chk("rstmid_start_ignored", busy[0], 0);
    reset = 1'b0; start = 1'b0; adc_valid = 1'b0; waitreq = 1'b0;
    tick();
    chk("rstmid_idle_busy", busy[0], 0);
    chk("rstmid_idle_write", wr[0], 0);
    chk("rstmid_wcnt", wcnt[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
